wb_stage: RTL and testbench

WB_STAGE -- requirements
Module: wb_stage

---
 rtl/wb_stage.sv | 134 +++++++++++++
 tb/tb_wb_stage.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/wb_stage.sv
// Write-back stage: MEM/WB pipeline register, load extraction/extension,
// register-file write port, misaligned-load detection and retirement counter.
module wb_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_in,
  input  logic        RegWrite_in,
  input  logic        MemtoReg_in,
  input  logic        PC2Reg_in,
  input  logic [4:0]  rd_in,
  input  logic [2:0]  funct3_in,
  input  logic [31:0] alu_result_in,
  input  logic [31:0] mem_rdata_in,
  input  logic [31:0] pc_in,
  input  logic        err_clr,
  output logic        RegWrite,
  output logic [4:0]  rd_out,
  output logic [31:0] Write_data,
  output logic        load_misaligned,
  output logic        err_sticky,
  output logic [31:0] instret
);

  logic        valid_reg;
  logic        regwrite_reg;
  logic        memtoreg_reg;
  logic        pc2reg_reg;
  logic [4:0]  rd_reg;
  logic [2:0]  funct3_reg;
  logic [31:0] alu_reg;
  logic [31:0] mdata_reg;
  logic [31:0] pc_reg;
  logic        err_reg;
  logic [31:0] instret_reg;

  logic [7:0]  byte_lane [4];
  logic [15:0] half_lane [2];
  logic [7:0]  sel_byte;
  logic [15:0] sel_half;
  logic [31:0] load_data;
  logic        misaligned;
  logic        retire;

  // A bubble clears only the control bits; the datapath fields are don't-care.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_reg    <= 1'b0;
      regwrite_reg <= 1'b0;
      memtoreg_reg <= 1'b0;
      pc2reg_reg   <= 1'b0;
      rd_reg       <= 5'd0;
      funct3_reg   <= 3'd0;
      alu_reg      <= 32'd0;
      mdata_reg    <= 32'd0;
      pc_reg       <= 32'd0;
    end else begin
      valid_reg    <= valid_in;
      regwrite_reg <= valid_in & RegWrite_in;
      memtoreg_reg <= valid_in & MemtoReg_in;
      pc2reg_reg   <= valid_in & PC2Reg_in;
      rd_reg       <= rd_in;
      funct3_reg   <= funct3_in;
      alu_reg      <= alu_result_in;
      mdata_reg    <= mem_rdata_in;
      pc_reg       <= pc_in;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_byte
      assign byte_lane[gi] = mdata_reg[8*gi +: 8];
    end
    for (gi = 0; gi < 2; gi++) begin : g_half
      assign half_lane[gi] = mdata_reg[16*gi +: 16];
    end
  endgenerate

  assign sel_byte = byte_lane[alu_reg[1:0]];
  assign sel_half = half_lane[alu_reg[1]];

  always_comb begin
    load_data  = mdata_reg;
    misaligned = 1'b0;
    case (funct3_reg)
      3'b000: load_data = {{24{sel_byte[7]}}, sel_byte};
      3'b100: load_data = {24'd0, sel_byte};
      3'b001: begin
        load_data  = {{16{sel_half[15]}}, sel_half};
        misaligned = alu_reg[0];
      end
      3'b101: begin
        load_data  = {16'd0, sel_half};
        misaligned = alu_reg[0];
      end
      default: begin
        load_data  = mdata_reg;
        misaligned = |alu_reg[1:0];
      end
    endcase
  end

  assign load_misaligned = valid_reg & memtoreg_reg & misaligned;
  assign retire          = valid_reg & ~load_misaligned;

  always_comb begin
    Write_data = alu_reg;
    if (pc2reg_reg)
      Write_data = pc_reg + 32'd4;
    else if (memtoreg_reg)
      Write_data = load_data;
  end

  assign RegWrite   = valid_reg & regwrite_reg & (rd_reg != 5'd0) & ~load_misaligned;
  assign rd_out     = rd_reg;
  assign err_sticky = err_reg;
  assign instret    = instret_reg;

  // Setting the error takes priority over a clear arriving on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_reg     <= 1'b0;
      instret_reg <= 32'd0;
    end else begin
      if (load_misaligned)
        err_reg <= 1'b1;
      else if (err_clr)
        err_reg <= 1'b0;
      if (retire)
        instret_reg <= instret_reg + 32'd1;
    end
  end

endmodule

// File: tb/tb_wb_stage.sv
// Directed testbench for wb_stage: loads, JAL, misalignment, x0, bubbles,
// counter wrap and asynchronous reset.
module tb_wb_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_in, RegWrite_in, MemtoReg_in, PC2Reg_in;
  logic [4:0]  rd_in;
  logic [2:0]  funct3_in;
  logic [31:0] alu_result_in, mem_rdata_in, pc_in;
  logic        err_clr;
  logic        RegWrite;
  logic [4:0]  rd_out;
  logic [31:0] Write_data;
  logic        load_misaligned;
  logic        err_sticky;
  logic [31:0] instret;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  wb_stage dut (
    .clk(clk), .rst(rst),
    .valid_in(valid_in), .RegWrite_in(RegWrite_in), .MemtoReg_in(MemtoReg_in),
    .PC2Reg_in(PC2Reg_in), .rd_in(rd_in), .funct3_in(funct3_in),
    .alu_result_in(alu_result_in), .mem_rdata_in(mem_rdata_in), .pc_in(pc_in),
    .err_clr(err_clr), .RegWrite(RegWrite), .rd_out(rd_out),
    .Write_data(Write_data), .load_misaligned(load_misaligned),
    .err_sticky(err_sticky), .instret(instret)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Apply one instruction, let it be captured, then sit at the falling edge.
  task automatic drive(input logic v, input logic rw, input logic m2r, input logic pc2,
                       input logic [4:0] rd, input logic [2:0] f3, input logic [31:0] alu,
                       input logic [31:0] md, input logic [31:0] pc, input logic clr);
    valid_in = v; RegWrite_in = rw; MemtoReg_in = m2r; PC2Reg_in = pc2;
    rd_in = rd; funct3_in = f3; alu_result_in = alu; mem_rdata_in = md;
    pc_in = pc; err_clr = clr;
    @(posedge clk);
    @(negedge clk);
    $display("step t=%0t v=%0b rd=%0d f3=%0b alu=%h -> RegWrite=%0b Write_data=%h mis=%0b err=%0b instret=%0d",
             $time, v, rd, f3, alu, RegWrite, Write_data, load_misaligned, err_sticky, instret);
  endtask

  localparam logic [31:0] MD = 32'h80FF7F01;

  initial begin
    rst = 1'b1;
    valid_in = 0; RegWrite_in = 0; MemtoReg_in = 0; PC2Reg_in = 0;
    rd_in = 0; funct3_in = 0; alu_result_in = 0; mem_rdata_in = 0; pc_in = 0; err_clr = 0;
    #3;
    chk("rst_regwrite", {31'd0, RegWrite}, 32'd0);
    chk("rst_rd_out", {27'd0, rd_out}, 32'd0);
    chk("rst_wdata", Write_data, 32'd0);
    chk("rst_mis", {31'd0, load_misaligned}, 32'd0);
    chk("rst_err", {31'd0, err_sticky}, 32'd0);
    chk("rst_instret", instret, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // ALU op
    drive(1, 1, 0, 0, 5'd5, 3'b000, 32'h12345678, 32'h0, 32'h0, 0);
    chk("alu_regwrite", {31'd0, RegWrite}, 32'd1);
    chk("alu_rd", {27'd0, rd_out}, 32'd5);
    chk("alu_wdata", Write_data, 32'h12345678);
    chk("alu_instret", instret, 32'd0);

    // Loads from 0x80FF7F01
    drive(1, 1, 1, 0, 5'd6, 3'b000, 32'h00001002, MD, 32'h0, 0);
    chk("lb_wdata", Write_data, 32'hFFFFFFFF);
    chk("lb_regwrite", {31'd0, RegWrite}, 32'd1);
    chk("lb_instret", instret, 32'd1);
    drive(1, 1, 1, 0, 5'd6, 3'b100, 32'h00001003, MD, 32'h0, 0);
    chk("lbu_wdata", Write_data, 32'h00000080);
    chk("lbu_instret", instret, 32'd2);
    drive(1, 1, 1, 0, 5'd6, 3'b001, 32'h00001002, MD, 32'h0, 0);
    chk("lh_wdata", Write_data, 32'hFFFF80FF);
    chk("lh_mis", {31'd0, load_misaligned}, 32'd0);
    drive(1, 1, 1, 0, 5'd6, 3'b101, 32'h00001000, MD, 32'h0, 0);
    chk("lhu_wdata", Write_data, 32'h00007F01);
    drive(1, 1, 1, 0, 5'd6, 3'b010, 32'h00001000, MD, 32'h0, 0);
    chk("lw_wdata", Write_data, 32'h80FF7F01);
    chk("lw_instret", instret, 32'd5);

    // JAL
    drive(1, 1, 1, 1, 5'd1, 3'b010, 32'h00000000, MD, 32'h00000FFC, 0);
    chk("jal_wdata", Write_data, 32'h00001000);
    chk("jal_regwrite", {31'd0, RegWrite}, 32'd1);
    chk("jal_instret", instret, 32'd6);

    // Misaligned LW
    drive(1, 1, 1, 0, 5'd3, 3'b010, 32'h00000102, MD, 32'h0, 0);
    chk("mis_regwrite", {31'd0, RegWrite}, 32'd0);
    chk("mis_flag", {31'd0, load_misaligned}, 32'd1);
    chk("mis_err_before", {31'd0, err_sticky}, 32'd0);
    chk("mis_instret", instret, 32'd7);
    // Second misaligned (LH at odd address) follows directly
    drive(1, 1, 1, 0, 5'd3, 3'b001, 32'h00000101, MD, 32'h0, 0);
    chk("mis2_err", {31'd0, err_sticky}, 32'd1);
    chk("mis2_flag", {31'd0, load_misaligned}, 32'd1);
    chk("mis2_instret", instret, 32'd7);
    // Clear coincides with the edge ending the misaligned cycle: set wins
    drive(0, 0, 0, 0, 5'd0, 3'b000, 32'h0, 32'h0, 32'h0, 1);
    chk("setwins_err", {31'd0, err_sticky}, 32'd1);
    chk("bubble_flag", {31'd0, load_misaligned}, 32'd0);
    chk("bubble_regwrite", {31'd0, RegWrite}, 32'd0);
    chk("bubble_instret", instret, 32'd7);
    // Clear alone; x0 write in WB
    drive(1, 1, 0, 0, 5'd0, 3'b000, 32'h0000ABCD, 32'h0, 32'h0, 1);
    chk("clr_err", {31'd0, err_sticky}, 32'd0);
    chk("x0_regwrite", {31'd0, RegWrite}, 32'd0);
    chk("x0_instret_pre", instret, 32'd7);
    drive(1, 1, 0, 0, 5'd7, 3'b000, 32'h000000AA, 32'h0, 32'h0, 0);
    chk("x0_instret", instret, 32'd8);
    chk("rd7_regwrite", {31'd0, RegWrite}, 32'd1);

    // Counter wrap
    force dut.instret_reg = 32'hFFFFFFFF;
    #1;
    release dut.instret_reg;
    chk("force_instret", instret, 32'hFFFFFFFF);
    valid_in = 1'b0;
    @(negedge clk);
    chk("force_instret_hold", instret, 32'h0);
    drive(0, 1, 0, 0, 5'd8, 3'b000, 32'h0, 32'h0, 32'h0, 0);
    chk("wrap_bubble_instret", instret, 32'h0);
    chk("wrap_bubble_regwrite", {31'd0, RegWrite}, 32'd0);

    // Async reset mid-stream with err and instret nonzero
    drive(1, 1, 0, 0, 5'd2, 3'b000, 32'h11, 32'h0, 32'h0, 0);
    drive(1, 1, 1, 0, 5'd4, 3'b010, 32'h00000001, MD, 32'h0, 0);
    chk("pre_rst_instret", instret, 32'd1);
    drive(1, 1, 0, 0, 5'd9, 3'b000, 32'h00000055, 32'h0, 32'h0, 0);
    chk("pre_rst_regwrite", {31'd0, RegWrite}, 32'd1);
    chk("pre_rst_err", {31'd0, err_sticky}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("arst_regwrite", {31'd0, RegWrite}, 32'd0);
    chk("arst_wdata", Write_data, 32'd0);
    chk("arst_instret", instret, 32'd0);
    chk("arst_err", {31'd0, err_sticky}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    drive(1, 1, 0, 0, 5'd6, 3'b000, 32'h00000077, 32'h0, 32'h0, 0);
    chk("post_rst_wdata", Write_data, 32'h00000077);
    chk("post_rst_regwrite", {31'd0, RegWrite}, 32'd1);
    chk("post_rst_instret", instret, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
